// File: rtl/dest_track_fwd.sv
// Destination tracking through EX/MEM/WB with forwarding selects and load-use stall.
// Optional ID-stage bypass outputs are enabled by defining DEST_TRACK_ID_BYPASS_EN.
module dest_track_fwd #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Dest_id,
  input  logic                  RegWrite_id,
  input  logic                  MemRead_id,
  input  logic [REG_ADDR_W-1:0] Rs_id,
  input  logic [REG_ADDR_W-1:0] Rt_id,
  input  logic                  Uses_rt_id,
  input  logic                  Stall,
  input  logic                  Flush_id,
  output logic                  Hazard_stall,
  output logic [1:0]            Fwd_a,
  output logic [1:0]            Fwd_b,
  output logic [REG_ADDR_W-1:0] Wb_dest,
  output logic                  Wb_we
`ifdef DEST_TRACK_ID_BYPASS_EN
  ,
  output logic                  Byp_rs_id,
  output logic                  Byp_rt_id
`endif
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

  logic                  ex_valid_r, ex_we_r, ex_ld_r;
  logic [REG_ADDR_W-1:0] ex_dest_r, ex_rs_r, ex_rt_r;
  logic                  mem_valid_r, mem_we_r, mem_ld_r;
  logic [REG_ADDR_W-1:0] mem_dest_r;
  logic                  wb_valid_r, wb_we_r;
  logic [REG_ADDR_W-1:0] wb_dest_r;

  logic                  hazard_s, id_bubble_s;
  logic                  mem_live_s, wb_live_s;
  logic                  id_valid_s, id_we_s, id_ld_s;
  logic [REG_ADDR_W-1:0] id_dest_s, id_rs_s, id_rt_s;

  // A load in MEM is never a forwarding source; its consumer waits one bubble for WB.
  function automatic logic [1:0] fwd_sel(
    input logic                  mem_live,
    input logic                  mem_ld,
    input logic [REG_ADDR_W-1:0] mem_dest,
    input logic                  wb_live,
    input logic [REG_ADDR_W-1:0] wb_dest,
    input logic [REG_ADDR_W-1:0] src
  );
    logic [1:0] sel;
    if (mem_live && !mem_ld && (mem_dest == src)) begin
      sel = 2'b01;
    end else if (wb_live && (wb_dest == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Load-use hazard detection against the instruction currently in ID.
  always_comb begin
    hazard_s = 1'b0;
    if (ex_valid_r && ex_ld_r && ex_we_r && (ex_dest_r != REG_ZERO) && !Flush_id) begin
      hazard_s = (ex_dest_r == Rs_id) || (Uses_rt_id && (ex_dest_r == Rt_id));
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign id_bubble_s = Flush_id | hazard_s;

  // Build the entry entering EX: a real instruction or an all-zero bubble.
  always_comb begin
    id_valid_s = 1'b0;
    id_we_s    = 1'b0;
    id_ld_s    = 1'b0;
    id_dest_s  = REG_ZERO;
    id_rs_s    = REG_ZERO;
    id_rt_s    = REG_ZERO;
    if (id_bubble_s) begin
      id_valid_s = 1'b0;
    end else begin
      id_valid_s = 1'b1;
      id_we_s    = RegWrite_id;
      id_ld_s    = MemRead_id;
      id_dest_s  = Dest_id;
      id_rs_s    = Rs_id;
      id_rt_s    = Uses_rt_id ? Rt_id : REG_ZERO;
    end
  end

  // Slot advance; Stall freezes every slot, taking precedence over hazard and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_r  <= 1'b0;
      ex_we_r     <= 1'b0;
      ex_ld_r     <= 1'b0;
      ex_dest_r   <= REG_ZERO;
      ex_rs_r     <= REG_ZERO;
      ex_rt_r     <= REG_ZERO;
      mem_valid_r <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_ld_r    <= 1'b0;
      mem_dest_r  <= REG_ZERO;
      wb_valid_r  <= 1'b0;
      wb_we_r     <= 1'b0;
      wb_dest_r   <= REG_ZERO;
    end else if (!Stall) begin
      wb_valid_r  <= mem_valid_r;
      wb_we_r     <= mem_we_r;
      wb_dest_r   <= mem_dest_r;
      mem_valid_r <= ex_valid_r;
      mem_we_r    <= ex_we_r;
      mem_ld_r    <= ex_ld_r;
      mem_dest_r  <= ex_dest_r;
      ex_valid_r  <= id_valid_s;
      ex_we_r     <= id_we_s;
      ex_ld_r     <= id_ld_s;
      ex_dest_r   <= id_dest_s;
      ex_rs_r     <= id_rs_s;
      ex_rt_r     <= id_rt_s;
    end else begin
      ex_valid_r  <= ex_valid_r;
      mem_valid_r <= mem_valid_r;
      wb_valid_r  <= wb_valid_r;
    end
  end

  assign mem_live_s = mem_valid_r & mem_we_r & (mem_dest_r != REG_ZERO);
  assign wb_live_s  = wb_valid_r & wb_we_r & (wb_dest_r != REG_ZERO);

  assign Hazard_stall = hazard_s;
  assign Fwd_a   = fwd_sel(mem_live_s, mem_ld_r, mem_dest_r, wb_live_s, wb_dest_r, ex_rs_r);
  assign Fwd_b   = fwd_sel(mem_live_s, mem_ld_r, mem_dest_r, wb_live_s, wb_dest_r, ex_rt_r);
  assign Wb_we   = wb_live_s;
  assign Wb_dest = wb_valid_r ? wb_dest_r : REG_ZERO;

`ifdef DEST_TRACK_ID_BYPASS_EN
  assign Byp_rs_id = wb_live_s & (wb_dest_r == Rs_id);
  assign Byp_rt_id = wb_live_s & Uses_rt_id & (wb_dest_r == Rt_id);
`endif

endmodule
